// File: rtl/platform_led_pwm_driver_if.sv
// Avalon-MM slave bus of the LED PWM driver: word address, select,
// active-low write strobe and zero-wait-state read data.
interface platform_led_pwm_driver_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/platform_led_pwm_driver.sv
// LED driver behind the LED PIO: global PWM dimming and per-LED blinking.
// Pattern and settings are shadowed only at PWM frame boundaries so the LEDs never glitch.
module platform_led_pwm_driver #(
    parameter int LED_WIDTH = 10,
    parameter int PRESCALE  = 50,
    parameter int PWM_BITS  = 8,
    parameter int BLINK_RST = 1953
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [LED_WIDTH-1:0]        led_pattern,
    platform_led_pwm_driver_if.slave    bus,
    output logic [LED_WIDTH-1:0]        led_out
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0]     pre_cnt_r;
    logic [PWM_BITS-1:0]  pwm_cnt_r;
    logic [PWM_BITS-1:0]  duty_r;
    logic [PWM_BITS-1:0]  duty_sh_r;
    logic [LED_WIDTH-1:0] mask_r;
    logic [LED_WIDTH-1:0] mask_sh_r;
    logic [LED_WIDTH-1:0] pat_sh_r;
    logic [15:0]          half_r;
    logic [15:0]          frm_cnt_r;
    logic                 blink_phase_r;

    logic step_s;
    logic frame_end_s;
    logic wr_s;
    logic half_wr_s;
    logic pwm_on_s;

    assign step_s      = (pre_cnt_r == PRE_LAST);
    assign frame_end_s = step_s & (pwm_cnt_r == {PWM_BITS{1'b1}});
    assign wr_s        = bus.chipselect & ~bus.write_n;
    assign half_wr_s   = wr_s & (bus.address == 2'd2);
    assign pwm_on_s    = (duty_sh_r == {PWM_BITS{1'b1}}) | (pwm_cnt_r < duty_sh_r);

    // Prescaler and PWM step counter; the PWM counter wraps naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            pwm_cnt_r <= {PWM_BITS{1'b0}};
        end else if (step_s) begin
            pre_cnt_r <= {PRE_W{1'b0}};
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end else begin
            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
            pwm_cnt_r <= pwm_cnt_r;
        end
    end

    // Software-visible control registers; the status word is read-only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            duty_r <= {PWM_BITS{1'b1}};
            mask_r <= {LED_WIDTH{1'b0}};
            half_r <= 16'(BLINK_RST);
        end else if (wr_s) begin
            case (bus.address)
                2'd0:    duty_r <= bus.writedata[PWM_BITS-1:0];
                2'd1:    mask_r <= bus.writedata[LED_WIDTH-1:0];
                2'd2:    half_r <= bus.writedata[15:0];
                default: duty_r <= duty_r;
            endcase
        end else begin
            duty_r <= duty_r;
        end
    end

    // Frame-boundary shadows; a write on the same edge lands one frame later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_sh_r  <= {LED_WIDTH{1'b0}};
            duty_sh_r <= {PWM_BITS{1'b1}};
            mask_sh_r <= {LED_WIDTH{1'b0}};
        end else if (frame_end_s) begin
            pat_sh_r  <= led_pattern;
            duty_sh_r <= duty_r;
            mask_sh_r <= mask_r;
        end else begin
            pat_sh_r  <= pat_sh_r;
        end
    end

    // Blink timebase in frames; a half-period write restarts it in the lit phase.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frm_cnt_r     <= 16'd0;
            blink_phase_r <= 1'b1;
        end else if (half_wr_s || (half_r == 16'd0)) begin
            frm_cnt_r     <= 16'd0;
            blink_phase_r <= 1'b1;
        end else if (frame_end_s) begin
            if (frm_cnt_r == (half_r - 16'd1)) begin
                frm_cnt_r     <= 16'd0;
                blink_phase_r <= ~blink_phase_r;
            end else begin
                frm_cnt_r     <= frm_cnt_r + 16'd1;
            end
        end else begin
            frm_cnt_r <= frm_cnt_r;
        end
    end

    // Registered LED drive: pattern gated by PWM and by blink on masked LEDs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_out <= {LED_WIDTH{1'b0}};
        end else begin
            led_out <= pat_sh_r & {LED_WIDTH{pwm_on_s}}
                       & (~mask_sh_r | {LED_WIDTH{blink_phase_r}});
        end
    end

    // Zero-wait-state read mux; unused bits read as zero.
    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0:    bus.readdata[PWM_BITS-1:0]  = duty_r;
            2'd1:    bus.readdata[LED_WIDTH-1:0] = mask_r;
            2'd2:    bus.readdata[15:0]          = half_r;
            2'd3:    bus.readdata[LED_WIDTH:0]   = {blink_phase_r, pat_sh_r};
            default: bus.readdata                = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_platform_led_pwm_driver.sv
// Randomized bench for platform_led_pwm_driver with a frame-level reference
// model derived from absolute cycle counts since reset release.
module tb_platform_led_pwm_driver;
    localparam int LW    = 10;
    localparam int PS    = 2;
    localparam int PB    = 4;
    localparam int BR    = 1953;
    localparam int STEPS = 1 << PB;
    localparam int FRAME = PS * STEPS;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [LW-1:0] led_pattern = '0;
    logic [LW-1:0] led_out;
    logic [LW-1:0] cur_pat = '0;

    platform_led_pwm_driver_if bus();

    platform_led_pwm_driver #(
        .LED_WIDTH(LW), .PRESCALE(PS), .PWM_BITS(PB), .BLINK_RST(BR)
    ) dut (
        .clk(clk), .reset_n(reset_n), .led_pattern(led_pattern),
        .bus(bus), .led_out(led_out)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miscmp = 0;

    // reference model state
    int            k;
    logic [PB-1:0] m_duty, m_duty_sh;
    logic [LW-1:0] m_mask, m_mask_sh, m_pat_sh;
    logic [15:0]   m_half;
    int            m_frames;
    bit            m_phase;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; m_duty = '1; m_duty_sh = '1; m_mask = '0; m_mask_sh = '0;
        m_pat_sh = '0; m_half = 16'(BR); m_frames = 0; m_phase = 1'b1;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r = '0;
        case (a)
            2'd0: r[PB-1:0] = m_duty;
            2'd1: r[LW-1:0] = m_mask;
            2'd2: r[15:0]   = m_half;
            default: r[LW:0] = {m_phase, m_pat_sh};
        endcase
        return r;
    endfunction

    // LED drive expected on the edge about to happen (edge number k).
    function automatic logic [LW-1:0] model_led();
        int pos = (k / PS) % STEPS;
        bit on = (int'(m_duty_sh) == STEPS - 1) || (pos < int'(m_duty_sh));
        logic [LW-1:0] vis = m_phase ? {LW{1'b1}} : ~m_mask_sh;
        return on ? (m_pat_sh & vis) : '0;
    endfunction

    task automatic model_step(input bit wr, input logic [1:0] a, input logic [31:0] d);
        bit fe = (k % FRAME) == FRAME - 1;
        if ((wr && a == 2'd2) || m_half == 16'd0) begin
            m_frames = 0; m_phase = 1'b1;
        end else if (fe) begin
            m_frames++;
            if (m_frames == int'(m_half)) begin
                m_frames = 0; m_phase = !m_phase;
            end
        end
        if (fe) begin
            m_pat_sh = cur_pat; m_duty_sh = m_duty; m_mask_sh = m_mask;
        end
        if (wr) begin
            case (a)
                2'd0: m_duty = d[PB-1:0];
                2'd1: m_mask = d[LW-1:0];
                2'd2: m_half = d[15:0];
                default: ;
            endcase
        end
        k++;
    endtask

    // One clock: drive bus at negedge, optionally check readdata, check led_out after edge.
    task automatic do_cycle(input bit wr, input bit rd, input logic [1:0] a, input logic [31:0] d);
        logic [LW-1:0] exp;
        @(negedge clk);
        led_pattern    = cur_pat;
        bus.address    = a;
        bus.chipselect = wr | rd;
        bus.write_n    = ~wr;
        bus.writedata  = d;
        #1;
        if (rd) check_value($sformatf("rd_reg%0d", a), bus.readdata, model_read(a));
        exp = model_led();
        model_step(wr, a, d);
        @(posedge clk);
        #1;
        check_value("led_out", {22'd0, led_out}, {22'd0, exp});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 2'd0, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        bus.chipselect = 1'b0; bus.write_n = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check_value("rst_led_dark", {22'd0, led_out}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] st;
        int waited;
        bus.address = 2'd0; bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.writedata = 32'd0;
        cur_pat = 10'h3FF;
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_led_init", {22'd0, led_out}, 32'd0);
        reset_n = 1'b1;
        model_reset();

        // reset values, then full-on pattern through two frames
        for (int a = 0; a < 4; a++) do_cycle(1'b0, 1'b1, 2'(a), 32'd0);
        idle(2 * FRAME);

        // dimming: duty 4 then duty 0
        cur_pat = 10'h001;
        do_cycle(1'b1, 1'b0, 2'd0, 32'd4);
        idle(3 * FRAME);
        do_cycle(1'b1, 1'b0, 2'd0, 32'd0);
        idle(2 * FRAME);

        // blinking on bit1 only
        cur_pat = 10'h003;
        do_cycle(1'b1, 1'b0, 2'd0, 32'hF);
        do_cycle(1'b1, 1'b0, 2'd2, 32'd2);
        do_cycle(1'b1, 1'b0, 2'd1, 32'h002);
        idle(6 * FRAME);

        // duty write landing exactly on the frame_end edge
        while ((k % FRAME) != FRAME - 1) do_cycle(1'b0, 1'b0, 2'd0, 32'd0);
        do_cycle(1'b1, 1'b0, 2'd0, 32'd6);
        idle(3 * FRAME);

        // all-ones writes, unused bits read zero, status unaffected
        for (int a = 0; a < 4; a++) do_cycle(1'b1, 1'b0, 2'(a), 32'hFFFF_FFFF);
        for (int a = 0; a < 4; a++) do_cycle(1'b0, 1'b1, 2'(a), 32'd0);
        do_cycle(1'b1, 1'b0, 2'd2, 32'd2);
        do_cycle(1'b1, 1'b0, 2'd1, 32'h002);

        // reset during blink-off phase, observed through the status register
        waited = 0;
        st = 32'hFFFF_FFFF;
        while (st[LW] !== 1'b0 && waited < 8 * FRAME) begin
            do_cycle(1'b0, 1'b1, 2'd3, 32'd0);
            st = bus.readdata;
            waited++;
        end
        check_value("blink_off_seen", {31'd0, st[LW]}, 32'd0);
        idle(5);
        apply_reset();
        for (int a = 0; a < 4; a++) do_cycle(1'b0, 1'b1, 2'(a), 32'd0);
        idle(2 * FRAME);

        // randomized traffic
        for (int i = 0; i < 2500; i++) begin
            int r = $urandom_range(0, 99);
            logic [1:0] a = 2'($urandom_range(0, 3));
            logic [31:0] d = $urandom;
            if ($urandom_range(0, 19) == 0) cur_pat = LW'($urandom);
            if (a == 2'd2) d = 32'($urandom_range(0, 3));
            if (i == 1300) apply_reset();
            else if (r < 3) do_cycle(1'b1, 1'b0, a, d);
            else if (r < 13) do_cycle(1'b0, 1'b1, a, 32'd0);
            else do_cycle(1'b0, 1'b0, a, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
